// File: rtl/ispm_loader_if.sv
// Byte-stream input and BRAM write/read port bundle for ispm_loader.
// master = loader side, slave = stream source / BRAM side.
interface ispm_loader_if #(
    parameter int DATA = 32,
    parameter int ADDR = 10
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic            bram_wr;
    logic [ADDR-1:0] bram_addr;
    logic [DATA-1:0] bram_din;
    logic [DATA-1:0] bram_dout;

    modport master (
        input  in_valid, in_data, bram_dout,
        output in_ready, bram_wr, bram_addr, bram_din
    );

    modport slave (
        output in_valid, in_data, bram_dout,
        input  in_ready, bram_wr, bram_addr, bram_din
    );
endinterface

// File: rtl/ispm_loader.sv
// Boot-time byte-stream loader for the instruction scratchpad BRAM; holds the core until a good frame lands.
// Define ISPM_LOADER_VERIFY_EN to add a read-back checksum pass (VERIFY) before releasing the core.
module ispm_loader #(
    parameter int DATA = 32,
    parameter int ADDR = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    ispm_loader_if.master bus,
    output logic          hold_core,
    output logic          done,
    output logic          error
);
    // state  | meaning
    // IDLE   | hunting for 0xA5 magic, other bytes dropped
    // LEN0   | expecting word count low byte
    // LEN1   | expecting word count high byte
    // DATA   | assembling words, one BRAM write per BPW bytes
    // CSUM   | expecting checksum byte
    // VERIFY | reading the image back and re-summing (option only)
    // DONE   | image loaded, core released
    // ERR    | load failed, core held
    localparam int BPW = DATA / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [16:0] CAP = 17'd1 << ADDR;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM,
`ifdef ISPM_LOADER_VERIFY_EN
        S_VERIFY,
`endif
        S_DONE, S_ERR
    } state_t;

    state_t          state, state_nx, csum_nx;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [15:0]     n_full;
    logic [16:0]     word_idx;
    logic [BW-1:0]   byte_cnt;
    logic [DATA-1:0] word, word_nx;
    logic [7:0]      sum;
    logic            last_wr;
    logic            acc, tail, csum_ok, byte_last;

    assign bus.in_ready = (state == S_IDLE) || (state == S_LEN0) || (state == S_LEN1) ||
                          (state == S_DATA) || (state == S_CSUM);
    assign acc       = bus.in_valid && bus.in_ready;
    assign n_full    = {bus.in_data, len_lo};
    assign byte_last = (byte_cnt == BW'(BPW - 1));
    // Write cycle of the final word: a byte accepted here is already the checksum.
    assign tail      = (state == S_DATA) && bus.bram_wr && last_wr;
    assign csum_ok   = (bus.in_data == sum);

`ifdef ISPM_LOADER_VERIFY_EN
    logic [16:0] rd_idx, vcyc;
    logic [7:0]  vsum, dout_sum, vsum_fin;

    always_comb begin
        dout_sum = 8'd0;
        for (int b = 0; b < BPW; b++) dout_sum = dout_sum + bus.bram_dout[b*8 +: 8];
    end
    assign vsum_fin = vsum + dout_sum;
    assign csum_nx  = !csum_ok ? S_ERR : ((len == 16'd0) ? S_DONE : S_VERIFY);
`else
    logic unused_dout;
    assign unused_dout = ^bus.bram_dout;
    assign csum_nx     = csum_ok ? S_DONE : S_ERR;
`endif

    always_comb begin
        word_nx = word;
        for (int b = 0; b < BPW; b++)
            if (byte_cnt == BW'(b)) word_nx[b*8 +: 8] = bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (acc && bus.in_data == 8'hA5) state_nx = S_LEN0;
                S_LEN0: if (acc) state_nx = S_LEN1;
                S_LEN1: if (acc) begin
                    if ({1'b0, n_full} > CAP)  state_nx = S_ERR;
                    else if (n_full == 16'd0)  state_nx = S_CSUM;
                    else                       state_nx = S_DATA;
                end
                S_DATA: if (tail) state_nx = acc ? csum_nx : S_CSUM;
                S_CSUM: if (acc) state_nx = csum_nx;
`ifdef ISPM_LOADER_VERIFY_EN
                S_VERIFY: if (vcyc == {1'b0, len}) state_nx = (vsum_fin == sum) ? S_DONE : S_ERR;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo        <= '0;
            len           <= '0;
            word_idx      <= '0;
            byte_cnt      <= '0;
            word          <= '0;
            sum           <= '0;
            last_wr       <= 1'b0;
            bus.bram_wr   <= 1'b0;
            bus.bram_addr <= '0;
            bus.bram_din  <= '0;
            hold_core     <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
`ifdef ISPM_LOADER_VERIFY_EN
            rd_idx        <= '0;
            vcyc          <= '0;
            vsum          <= '0;
`endif
        end else begin
            bus.bram_wr <= 1'b0;
            if (start) begin
                done  <= 1'b0;
                error <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (acc && bus.in_data == 8'hA5) begin
                        word_idx      <= '0;
                        byte_cnt      <= '0;
                        sum           <= '0;
                        bus.bram_addr <= '0;
                        hold_core     <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                    end
                    S_LEN0: if (acc) len_lo <= bus.in_data;
                    S_LEN1: if (acc) len <= n_full;
                    S_DATA: if (acc && !tail) begin
                        word <= word_nx;
                        sum  <= sum + bus.in_data;
                        if (byte_last) begin
                            byte_cnt      <= '0;
                            bus.bram_wr   <= 1'b1;
                            bus.bram_addr <= word_idx[ADDR-1:0];
                            bus.bram_din  <= word_nx;
                            word_idx      <= word_idx + 17'd1;
                            last_wr       <= (word_idx + 17'd1 == {1'b0, len});
                        end else begin
                            byte_cnt <= byte_cnt + BW'(1);
                        end
                    end
`ifdef ISPM_LOADER_VERIFY_EN
                    S_VERIFY: begin
                        if (rd_idx < {1'b0, len}) begin
                            bus.bram_addr <= rd_idx[ADDR-1:0];
                            rd_idx        <= rd_idx + 17'd1;
                        end
                        if (vcyc != 17'd0) vsum <= vsum_fin;
                        vcyc <= vcyc + 17'd1;
                    end
`endif
                    default: ;
                endcase
`ifdef ISPM_LOADER_VERIFY_EN
                if (state_nx == S_VERIFY && state != S_VERIFY) begin
                    bus.bram_addr <= '0;
                    rd_idx        <= 17'd1;
                    vcyc          <= '0;
                    vsum          <= '0;
                end
`endif
                if (state_nx == S_DONE && state != S_DONE) begin
                    done      <= 1'b1;
                    hold_core <= 1'b0;
                end
                if (state_nx == S_ERR && state != S_ERR) begin
                    error     <= 1'b1;
                    hold_core <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ispm_loader.sv
// Self-checking bench for ispm_loader: fixed corner-case frames plus a table of randomized frames.
module tb_ispm_loader;
    localparam int DATA  = 32;
    localparam int ADDR  = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic hold_core, done, error;

    ispm_loader_if #(.DATA(DATA), .ADDR(ADDR)) bus();

    ispm_loader #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .hold_core(hold_core), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // BRAM model, registered read; corrupt_addr flips a bit on read-back of one address.
    logic [DATA-1:0] mem [DEPTH];
    int corrupt_addr = -1;
    always @(posedge clk) begin
        if (bus.bram_wr) mem[bus.bram_addr] <= bus.bram_din;
        bus.bram_dout <= mem[bus.bram_addr] ^ ((int'(bus.bram_addr) == corrupt_addr) ? 32'h0000_0100 : 32'h0);
    end

    typedef struct {int addr; logic [31:0] data;} wr_t;
    wr_t wr_log[$];
    always @(negedge clk) if (bus.bram_wr === 1'b1) wr_log.push_back(wr_t'{int'(bus.bram_addr), bus.bram_din});

    typedef struct {int n; logic [7:0] cx; int junk; bit exp_done; bit exp_err; int exp_wr;} vec_t;
    vec_t vecs [8];

    logic [7:0]  frm[$];
    logic [31:0] exp_words[$];
    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] f1 [12] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8};
    logic [7:0] f3 [10] = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    logic [7:0] f4 [8]  = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL send_byte: in_ready stayed low for 20 cycles, byte 0x%0h", b);
        end
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frm[i]) begin
            send_byte(frm[i]);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int i;
        i = 0;
        while (!(done === 1'b1 || error === 1'b1) && i < 60) begin
            @(negedge clk);
            i++;
        end
        if (!(done === 1'b1 || error === 1'b1)) begin
            n_checks++;
            $display("FAIL %s_timeout: done/error still low after 60 cycles", name);
        end
    endtask

    task automatic check_writes(input string tag, input int exp_n);
        check({tag, "_wr_count"}, wr_log.size(), exp_n);
        for (int i = 0; i < wr_log.size() && i < exp_words.size(); i++) begin
            check($sformatf("%s_wr%0d_addr", tag, i), wr_log[i].addr, i);
            check($sformatf("%s_wr%0d_data", tag, i), wr_log[i].data, exp_words[i]);
        end
    endtask

    // Reference frame builder: little-endian words, 8-bit sum over data bytes only.
    task automatic build_frame(input int n, input logic [7:0] cx, input int junk);
        logic [7:0]  s, b;
        logic [31:0] w;
        s = 8'h00;
        frm.delete();
        exp_words.delete();
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            frm.push_back(b);
        end
        frm.push_back(8'hA5);
        frm.push_back(8'(n));
        frm.push_back(8'(n >> 8));
        if (n > DEPTH) return;
        for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                b = 8'($urandom);
                frm.push_back(b);
                w = w | (32'(b) << (8 * k));
                s = s + b;
            end
            exp_words.push_back(w);
        end
        frm.push_back(s ^ cx);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        vecs[0] = '{1,  8'h00, 0, 1'b1, 1'b0, 1};
        vecs[1] = '{2,  8'h00, 2, 1'b1, 1'b0, 2};
        vecs[2] = '{2,  8'h01, 0, 1'b0, 1'b1, 2};
        vecs[3] = '{0,  8'h00, 0, 1'b1, 1'b0, 0};
        vecs[4] = '{16, 8'h00, 1, 1'b1, 1'b0, 16};
        vecs[5] = '{17, 8'h00, 0, 1'b0, 1'b1, 0};
        vecs[6] = '{3,  8'h80, 1, 1'b0, 1'b1, 3};
        vecs[7] = '{5,  8'h00, 3, 1'b1, 1'b0, 5};

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_bram_wr", bus.bram_wr, 0);
        check("rst_bram_addr", bus.bram_addr, 0);
        check("rst_bram_din", bus.bram_din, 0);
        check("rst_hold_core", hold_core, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word frame, data-byte sum 0xB8.
        frm.delete();
        foreach (f1[i]) frm.push_back(f1[i]);
        exp_words.delete();
        exp_words.push_back(32'h44332211);
        exp_words.push_back(32'hDDCCBBAA);
        wr_log.delete();
        send_frame(1'b0);
        wait_end("a");
        check_writes("a", 2);
        check("a_done", done, 1);
        check("a_hold_core", hold_core, 0);
        check("a_error", error, 0);
        pulse_start();
        check("a_start_done", done, 0);
        check("a_start_hold_kept", hold_core, 0);
        check("a_start_in_ready", bus.in_ready, 1);

        // Same frame, bad checksum.
        frm[11] = 8'h55;
        wr_log.delete();
        send_frame(1'b0);
        wait_end("b");
        check("b_error", error, 1);
        check("b_hold_core", hold_core, 1);
        check("b_done", done, 0);
        check("b_in_ready", bus.in_ready, 0);
        pulse_start();
        check("b_start_error", error, 0);
        check("b_start_in_ready", bus.in_ready, 1);

        // Junk before magic is dropped silently.
        frm.delete();
        foreach (f3[i]) frm.push_back(f3[i]);
        exp_words.delete();
        exp_words.push_back(32'h04030201);
        wr_log.delete();
        send_frame(1'b0);
        wait_end("c");
        check_writes("c", 1);
        check("c_done", done, 1);

        // Abort after five data bytes, then reload from address 0.
        pulse_start();
        frm.delete();
        foreach (f4[i]) frm.push_back(f4[i]);
        exp_words.delete();
        exp_words.push_back(32'h44332211);
        wr_log.delete();
        send_frame(1'b0);
        pulse_start();
        idle(2);
        check_writes("d_abort", 1);
        check("d_abort_done", done, 0);
        check("d_abort_error", error, 0);
        check("d_abort_in_ready", bus.in_ready, 1);
        frm.delete();
        foreach (f1[i]) frm.push_back(f1[i]);
        exp_words.push_back(32'hDDCCBBAA);
        wr_log.delete();
        send_frame(1'b1);
        wait_end("d_reload");
        check_writes("d_reload", 2);
        check("d_reload_done", done, 1);

        // Reset in the middle of a load.
        pulse_start();
        frm.delete();
        foreach (f4[i]) if (i < 5) frm.push_back(f4[i]);
        send_frame(1'b0);
        rst_n = 1'b0;
        #1;
        check("e_rst_hold_core", hold_core, 1);
        check("e_rst_bram_addr", bus.bram_addr, 0);
        check("e_rst_done", done, 0);
        check("e_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frm.delete();
        foreach (f3[i]) frm.push_back(f3[i]);
        exp_words.delete();
        exp_words.push_back(32'h04030201);
        wr_log.delete();
        send_frame(1'b0);
        wait_end("e");
        check_writes("e", 1);
        check("e_done", done, 1);

        // Randomized table rows against the reference frame builder.
        for (int v = 0; v < 8; v++) begin
            pulse_start();
            build_frame(vecs[v].n, vecs[v].cx, vecs[v].junk);
            wr_log.delete();
            send_frame(1'b1);
            wait_end($sformatf("vec%0d", v));
            check_writes($sformatf("vec%0d", v), vecs[v].exp_wr);
            check($sformatf("vec%0d_done", v), done, vecs[v].exp_done);
            check($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
            check($sformatf("vec%0d_hold_core", v), hold_core, !vecs[v].exp_done);
            check($sformatf("vec%0d_in_ready", v), bus.in_ready, 0);
        end

`ifdef ISPM_LOADER_VERIFY_EN
        // Read-back of address 1 is corrupted: the checksum byte is right but verify must fail.
        pulse_start();
        corrupt_addr = 1;
        frm.delete();
        foreach (f1[i]) frm.push_back(f1[i]);
        wr_log.delete();
        send_frame(1'b0);
        wait_end("v_bad");
        check("v_bad_error", error, 1);
        check("v_bad_done", done, 0);
        check("v_bad_hold_core", hold_core, 1);
        corrupt_addr = -1;
        pulse_start();
        wr_log.delete();
        send_frame(1'b0);
        wait_end("v_good");
        check("v_good_done", done, 1);
        check("v_good_error", error, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
